// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: holds the bus for power-up init, then grants refresh ahead of
// write/read (round-robin between those two) and drives the granted bundle onto registered pins.
module sdram_arbit #(
  parameter int TIMEOUT = 255
) (
  input  logic        sclk,
  input  logic        srst_n,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [10:0] init_addr,
  input  logic [1:0]  init_ba,
  input  logic        aref_req,
  output logic        aref_en,
  output logic        aref_ack,
  input  logic        aref_done,
  input  logic [3:0]  aref_cmd,
  input  logic [10:0] aref_addr,
  input  logic [1:0]  aref_ba,
  input  logic [31:0] aref_data,
  input  logic        aref_oe_n,
  input  logic [3:0]  aref_dqm,
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        wr_done,
  input  logic [3:0]  wr_cmd,
  input  logic [10:0] wr_addr,
  input  logic [1:0]  wr_ba,
  input  logic [31:0] wr_data,
  input  logic        wr_oe_n,
  input  logic [3:0]  wr_dqm,
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        rd_done,
  input  logic [3:0]  rd_cmd,
  input  logic [10:0] rd_addr,
  input  logic [1:0]  rd_ba,
  input  logic [3:0]  rd_dqm,
  output logic [3:0]  sdram_cmd,
  output logic [10:0] sdram_addr,
  output logic [1:0]  sdram_ba,
  output logic [31:0] sdram_dq,
  output logic        sdram_oe_n,
  output logic [3:0]  sdram_dqm,
  output logic        err_timeout
);

  typedef enum logic [4:0] {
    ST_INIT  = 5'b00001,
    ST_ARBIT = 5'b00010,
    ST_AREF  = 5'b00100,
    ST_WRITE = 5'b01000,
    ST_READ  = 5'b10000
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_wr_q, last_wr_d;
  logic [7:0]  grant_cnt_q, grant_cnt_d;
  logic        err_q, err_d;
  logic        grant_st, grant_done;

  logic [3:0]  cmd_q, cmd_d;
  logic [10:0] addr_q, addr_d;
  logic [1:0]  ba_q, ba_d;
  logic [31:0] dq_q, dq_d;
  logic        oe_n_q, oe_n_d;
  logic [3:0]  dqm_q, dqm_d;

  assign grant_st   = (state_q == ST_AREF) || (state_q == ST_WRITE) || (state_q == ST_READ);
  assign grant_done = ((state_q == ST_AREF)  && aref_done) ||
                      ((state_q == ST_WRITE) && wr_done)   ||
                      ((state_q == ST_READ)  && rd_done);

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      ST_INIT:  if (init_end) state_d = ST_ARBIT;
      ST_ARBIT: begin
        if (aref_req)                state_d = ST_AREF;
        else if (wr_req && rd_req)   state_d = last_wr_q ? ST_READ : ST_WRITE;
        else if (wr_req)             state_d = ST_WRITE;
        else if (rd_req)             state_d = ST_READ;
      end
      ST_AREF, ST_WRITE, ST_READ: begin
        // A done in the expiry cycle is a normal release, not a timeout
        if (grant_done) begin
          state_d = ST_ARBIT;
        end else if (grant_cnt_q == CNT_LAST) begin
          state_d = ST_ARBIT;
          err_d   = 1'b1;
        end
      end
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (state_d != state_q) grant_cnt_d = '0;
    else if (grant_st)      grant_cnt_d = grant_cnt_q + 8'd1;

    last_wr_d = last_wr_q;
    if (state_d == ST_WRITE && state_q != ST_WRITE)     last_wr_d = 1'b1;
    else if (state_d == ST_READ && state_q != ST_READ)  last_wr_d = 1'b0;
  end

  // Pin source mux; ARBIT (and any unexpected state) emits a NOP
  always_comb begin
    cmd_d  = 4'b0111;
    addr_d = '0;
    ba_d   = '0;
    dq_d   = '0;
    oe_n_d = 1'b1;
    dqm_d  = 4'hF;
    case (state_q)
      ST_INIT: begin
        cmd_d  = init_cmd;
        addr_d = init_addr;
        ba_d   = init_ba;
        dqm_d  = 4'h0;
      end
      ST_AREF: begin
        cmd_d  = aref_cmd;
        addr_d = aref_addr;
        ba_d   = aref_ba;
        dq_d   = aref_data;
        oe_n_d = aref_oe_n;
        dqm_d  = aref_dqm;
      end
      ST_WRITE: begin
        cmd_d  = wr_cmd;
        addr_d = wr_addr;
        ba_d   = wr_ba;
        dq_d   = wr_data;
        oe_n_d = wr_oe_n;
        dqm_d  = wr_dqm;
      end
      ST_READ: begin
        cmd_d  = rd_cmd;
        addr_d = rd_addr;
        ba_d   = rd_ba;
        dqm_d  = rd_dqm;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q     <= ST_INIT;
      last_wr_q   <= 1'b0;
      grant_cnt_q <= '0;
      err_q       <= 1'b0;
      cmd_q       <= 4'b1111;
      addr_q      <= '0;
      ba_q        <= '0;
      dq_q        <= '0;
      oe_n_q      <= 1'b1;
      dqm_q       <= 4'hF;
    end else begin
      state_q     <= state_d;
      last_wr_q   <= last_wr_d;
      grant_cnt_q <= grant_cnt_d;
      err_q       <= err_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      ba_q        <= ba_d;
      dq_q        <= dq_d;
      oe_n_q      <= oe_n_d;
      dqm_q       <= dqm_d;
    end
  end

  assign aref_en     = (state_q == ST_AREF);
  assign aref_ack    = (state_q == ST_AREF);
  assign wr_en       = (state_q == ST_WRITE);
  assign rd_en       = (state_q == ST_READ);
  assign err_timeout = err_q;

  assign sdram_cmd   = cmd_q;
  assign sdram_addr  = addr_q;
  assign sdram_ba    = ba_q;
  assign sdram_dq    = dq_q;
  assign sdram_oe_n  = oe_n_q;
  assign sdram_dqm   = dqm_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: scenario tasks with inline checks; pin outputs go through an
// expected-value queue filled when each cycle's sources are driven.
module tb_sdram_arbit;

  logic        sclk = 1'b0;
  logic        srst_n = 1'b0;
  logic        init_end = 1'b0;
  logic [3:0]  init_cmd = '0;
  logic [10:0] init_addr = '0;
  logic [1:0]  init_ba = '0;
  logic        aref_req = 1'b0, aref_done = 1'b0;
  logic        aref_en, aref_ack;
  logic [3:0]  aref_cmd = '0;
  logic [10:0] aref_addr = '0;
  logic [1:0]  aref_ba = '0;
  logic [31:0] aref_data = '0;
  logic        aref_oe_n = 1'b1;
  logic [3:0]  aref_dqm = '0;
  logic        wr_req = 1'b0, wr_done = 1'b0;
  logic        wr_en;
  logic [3:0]  wr_cmd = '0;
  logic [10:0] wr_addr = '0;
  logic [1:0]  wr_ba = '0;
  logic [31:0] wr_data = '0;
  logic        wr_oe_n = 1'b1;
  logic [3:0]  wr_dqm = '0;
  logic        rd_req = 1'b0, rd_done = 1'b0;
  logic        rd_en;
  logic [3:0]  rd_cmd = '0;
  logic [10:0] rd_addr = '0;
  logic [1:0]  rd_ba = '0;
  logic [3:0]  rd_dqm = '0;
  logic [3:0]  sdram_cmd;
  logic [10:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic [31:0] sdram_dq;
  logic        sdram_oe_n;
  logic [3:0]  sdram_dqm;
  logic        err_timeout;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [10:0] addr;
    logic [1:0]  ba;
    logic [31:0] dq;
    logic        oe_n;
    logic [3:0]  dqm;
  } pins_t;

  typedef enum int {S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ} st_t;

  localparam pins_t RST_PINS = {4'b1111, 11'h0, 2'h0, 32'h0, 1'b1, 4'hF};

  pins_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  sdram_arbit #(.TIMEOUT(8)) dut (
    .sclk(sclk), .srst_n(srst_n), .init_end(init_end),
    .init_cmd(init_cmd), .init_addr(init_addr), .init_ba(init_ba),
    .aref_req(aref_req), .aref_en(aref_en), .aref_ack(aref_ack), .aref_done(aref_done),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_ba(aref_ba), .aref_data(aref_data),
    .aref_oe_n(aref_oe_n), .aref_dqm(aref_dqm),
    .wr_req(wr_req), .wr_en(wr_en), .wr_done(wr_done),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba), .wr_data(wr_data),
    .wr_oe_n(wr_oe_n), .wr_dqm(wr_dqm),
    .rd_req(rd_req), .rd_en(rd_en), .rd_done(rd_done),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba), .rd_dqm(rd_dqm),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
    .sdram_dq(sdram_dq), .sdram_oe_n(sdram_oe_n), .sdram_dqm(sdram_dqm),
    .err_timeout(err_timeout)
  );

  always #5 sclk = ~sclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  function automatic pins_t cur_pins();
    return {sdram_cmd, sdram_addr, sdram_ba, sdram_dq, sdram_oe_n, sdram_dqm};
  endfunction

  // Expected pin value one cycle after the arbiter sits in state s with the current inputs
  function automatic pins_t src_of(input st_t s);
    case (s)
      S_INIT:  return {init_cmd, init_addr, init_ba, 32'h0, 1'b1, 4'h0};
      S_AREF:  return {aref_cmd, aref_addr, aref_ba, aref_data, aref_oe_n, aref_dqm};
      S_WRITE: return {wr_cmd, wr_addr, wr_ba, wr_data, wr_oe_n, wr_dqm};
      S_READ:  return {rd_cmd, rd_addr, rd_ba, 32'h0, 1'b1, rd_dqm};
      default: return {4'b0111, 11'h0, 2'h0, 32'h0, 1'b1, 4'hF};
    endcase
  endfunction

  task automatic rand_bundles();
    init_cmd  = 4'($urandom);  init_addr = 11'($urandom); init_ba = 2'($urandom);
    aref_cmd  = 4'($urandom);  aref_addr = 11'($urandom); aref_ba = 2'($urandom);
    aref_data = $urandom;      aref_oe_n = 1'($urandom);  aref_dqm = 4'($urandom);
    wr_cmd    = 4'($urandom);  wr_addr   = 11'($urandom); wr_ba   = 2'($urandom);
    wr_data   = $urandom;      wr_oe_n   = 1'($urandom);  wr_dqm  = 4'($urandom);
    rd_cmd    = 4'($urandom);  rd_addr   = 11'($urandom); rd_ba   = 2'($urandom);
    rd_dqm    = 4'($urandom);
  endtask

  task automatic test_reset();
    pins_t e, g;
    srst_n = 1'b0;
    init_end = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    exp_q.delete();
    exp_q.push_back(RST_PINS);
    g = cur_pins(); e = exp_q.pop_front(); n_vec++;
    if (g !== e) begin
      n_err++; $display("FAIL reset_pins: got %h expected %h", g, e);
    end
    n_vec++;
    if ({aref_en, aref_ack, wr_en, rd_en, err_timeout} !== 5'b0) begin
      n_err++; $display("FAIL reset_outs: got %b expected 00000", {aref_en, aref_ack, wr_en, rd_en, err_timeout});
    end
    srst_n = 1'b1;
    exp_q.push_back(RST_PINS);
    for (int c = 0; c <= 7; c++) begin
      g = cur_pins(); e = exp_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_err++; $display("FAIL init_pins_c%0d: got %h expected %h", c, g, e);
      end
      n_vec++;
      if ({aref_en, wr_en, rd_en} !== 3'b000) begin
        n_err++; $display("FAIL init_en_c%0d: got %b expected 000", c, {aref_en, wr_en, rd_en});
      end
      rand_bundles();
      init_end = (c >= 5);
      exp_q.push_back(src_of((c >= 6) ? S_ARBIT : S_INIT));
      tick();
    end
  endtask

  task automatic test_priority();
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    tick();
    n_vec++;
    if ({aref_en, aref_ack, wr_en, rd_en} !== 4'b1100) begin
      n_err++; $display("FAIL prio_aref_grant: got %b expected 1100", {aref_en, aref_ack, wr_en, rd_en});
    end
    aref_req = 1'b0;
    tick(); tick();
    n_vec++;
    if ({aref_en, wr_en, rd_en} !== 3'b100) begin
      n_err++; $display("FAIL prio_aref_hold: got %b expected 100", {aref_en, wr_en, rd_en});
    end
    aref_done = 1'b1;
    tick();
    aref_done = 1'b0;
    n_vec++;
    if ({aref_en, aref_ack, wr_en, rd_en} !== 4'b0000) begin
      n_err++; $display("FAIL prio_gap: got %b expected 0000", {aref_en, aref_ack, wr_en, rd_en});
    end
    tick();
    n_vec++;
    if ({aref_en, wr_en, rd_en} !== 3'b010) begin
      n_err++; $display("FAIL prio_write_first_tie: got %b expected 010", {aref_en, wr_en, rd_en});
    end
    wr_req = 1'b0; rd_req = 1'b0;
    tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    n_vec++;
    if ({aref_en, wr_en, rd_en} !== 3'b000) begin
      n_err++; $display("FAIL prio_wr_release: got %b expected 000", {aref_en, wr_en, rd_en});
    end
  endtask

  // Last grant was a write, so a held tie alternates R,W,R,W
  task automatic test_round_robin();
    logic       want_wr;
    logic [3:0] prev_cmd;
    wr_cmd = 4'b0100; rd_cmd = 4'b0101;
    wr_req = 1'b1; rd_req = 1'b1;
    prev_cmd = 4'b0111;
    for (int g = 0; g < 4; g++) begin
      want_wr = (g % 2 == 1);
      n_vec++;
      if ({aref_en, wr_en, rd_en} !== 3'b000) begin
        n_err++; $display("FAIL rr_gap_%0d: got %b expected 000", g, {aref_en, wr_en, rd_en});
      end
      if (g > 0) begin
        n_vec++;
        if (sdram_cmd !== prev_cmd) begin
          n_err++; $display("FAIL rr_tail_cmd_%0d: got %b expected %b", g, sdram_cmd, prev_cmd);
        end
      end
      tick();
      n_vec++;
      if ({wr_en, rd_en} !== (want_wr ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL rr_grant_%0d: got %b expected %b", g, {wr_en, rd_en}, (want_wr ? 2'b10 : 2'b01));
      end
      n_vec++;
      if (sdram_cmd !== 4'b0111) begin
        n_err++; $display("FAIL rr_nop_%0d: got %b expected 0111", g, sdram_cmd);
      end
      tick();
      prev_cmd = want_wr ? 4'b0100 : 4'b0101;
      n_vec++;
      if (sdram_cmd !== prev_cmd) begin
        n_err++; $display("FAIL rr_cmd_%0d: got %b expected %b", g, sdram_cmd, prev_cmd);
      end
      tick();
      if (want_wr) wr_done = 1'b1;
      else         rd_done = 1'b1;
      if (g == 3) begin
        wr_req = 1'b0; rd_req = 1'b0;
      end
      tick();
      wr_done = 1'b0; rd_done = 1'b0;
    end
    n_vec++;
    if ({aref_en, wr_en, rd_en} !== 3'b000) begin
      n_err++; $display("FAIL rr_end: got %b expected 000", {aref_en, wr_en, rd_en});
    end
  endtask

  task automatic test_pins();
    pins_t e, g;
    st_t   gs;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      gs = (k == 0) ? S_AREF : (k == 1) ? S_WRITE : S_READ;
      for (int c = 0; c < 5; c++) begin
        if (exp_q.size() > 0) begin
          g = cur_pins(); e = exp_q.pop_front(); n_vec++;
          if (g !== e) begin
            n_err++; $display("FAIL pins_k%0d_c%0d: got %h expected %h", k, c, g, e);
          end
        end
        rand_bundles();
        if (k == 1 && c == 1) begin
          wr_cmd = 4'b0100; wr_data = 32'hA5A5_0001; wr_oe_n = 1'b0;
        end
        if (k == 2) begin
          wr_oe_n = 1'b0; aref_oe_n = 1'b0;
        end
        aref_req = (c == 0) && (gs == S_AREF);
        wr_req   = (c == 0) && (gs == S_WRITE);
        rd_req   = (c == 0) && (gs == S_READ);
        aref_done = (c == 3) && (gs == S_AREF);
        wr_done   = (c == 3) && (gs == S_WRITE);
        rd_done   = (c == 3) && (gs == S_READ);
        exp_q.push_back(src_of((c >= 1 && c <= 3) ? gs : S_ARBIT));
        tick();
        aref_done = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
      end
    end
    g = cur_pins(); e = exp_q.pop_front(); n_vec++;
    if (g !== e) begin
      n_err++; $display("FAIL pins_tail: got %h expected %h", g, e);
    end
  endtask

  task automatic test_timeout();
    int   cnt;
    logic exp_err;
    for (int r = 0; r < 2; r++) begin
      cnt = 0;
      exp_err = (r == 0);
      wr_req = 1'b1;
      tick();
      wr_req = 1'b0;
      while (wr_en === 1'b1 && cnt < 20) begin
        cnt++;
        n_vec++;
        if (err_timeout !== 1'b0) begin
          n_err++; $display("FAIL to_err_early_r%0d_%0d: got %b expected 0", r, cnt, err_timeout);
        end
        if (r == 0 && cnt == 3) begin
          rd_done = 1'b1; aref_done = 1'b1;
        end
        if (r == 1 && cnt == 8) wr_done = 1'b1;
        tick();
        rd_done = 1'b0; aref_done = 1'b0; wr_done = 1'b0;
      end
      n_vec++;
      if (cnt !== 8) begin
        n_err++; $display("FAIL to_len_r%0d: got %0d grant cycles expected 8", r, cnt);
      end
      n_vec++;
      if (err_timeout !== exp_err) begin
        n_err++; $display("FAIL to_err_pulse_r%0d: got %b expected %b", r, err_timeout, exp_err);
      end
      tick();
      n_vec++;
      if (err_timeout !== 1'b0) begin
        n_err++; $display("FAIL to_err_clear_r%0d: got %b expected 0", r, err_timeout);
      end
    end
  endtask

  task automatic test_reset_mid();
    pins_t e, g;
    rd_req = 1'b1;
    tick();
    n_vec++;
    if (rd_en !== 1'b1) begin
      n_err++; $display("FAIL rm_grant: got %b expected 1", rd_en);
    end
    #2;
    srst_n = 1'b0;
    #1;
    n_vec++;
    if ({aref_en, wr_en, rd_en, err_timeout} !== 4'b0000) begin
      n_err++; $display("FAIL rm_async_en: got %b expected 0000", {aref_en, wr_en, rd_en, err_timeout});
    end
    exp_q.delete();
    exp_q.push_back(RST_PINS);
    g = cur_pins(); e = exp_q.pop_front(); n_vec++;
    if (g !== e) begin
      n_err++; $display("FAIL rm_async_pins: got %h expected %h", g, e);
    end
    init_end = 1'b0;
    @(posedge sclk);
    #1;
    srst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (rd_en !== 1'b0) begin
        n_err++; $display("FAIL rm_no_grant_init_%0d: got %b expected 0", c, rd_en);
      end
    end
    init_end = 1'b1; rd_req = 1'b0;
    tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    n_vec++;
    if ({aref_en, wr_en, rd_en} !== 3'b000) begin
      n_err++; $display("FAIL rm_stray_done: got %b expected 000", {aref_en, wr_en, rd_en});
    end
    n_vec++;
    if (sdram_cmd !== 4'b0111) begin
      n_err++; $display("FAIL rm_nop: got %b expected 0111", sdram_cmd);
    end
    rd_req = 1'b1;
    tick();
    n_vec++;
    if (rd_en !== 1'b1) begin
      n_err++; $display("FAIL rm_regrant: got %b expected 1", rd_en);
    end
    rd_req = 1'b0; rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    n_vec++;
    if (rd_en !== 1'b0) begin
      n_err++; $display("FAIL rm_release: got %b expected 0", rd_en);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_round_robin();
    test_pins();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
